// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage hazard and stall controller.
// It detects load-use hazards that forwarding cannot cover. It tracks the
// multi-cycle mult/div unit and stalls HI/LO consumers while that unit is busy.
// A taken branch or jump resolved in EX becomes an IF/ID flush plus an ID/EX bubble.
// Optional build macro HAZARD_STATS_EN adds two saturating stall-cycle counters:
// load_stall_cnt and md_stall_cnt.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_reg_rs,
  input  logic [4:0]  ID_reg_rt,
  input  logic        ID_uses_rt,
  input  logic        ID_is_md,
  input  logic        ID_reads_hilo,
  input  logic        EX_mem_read,
  input  logic [4:0]  EX_reg_rt,
  input  logic        EX_redirect,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        md_busy,
`ifdef HAZARD_STATS_EN
  output logic [15:0] load_stall_cnt,
  output logic [15:0] md_stall_cnt,
`endif
  output logic [1:0]  stall_cause
);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_LOAD  = 2'b01;
  localparam logic [1:0] CAUSE_MD    = 2'b10;
  localparam logic [1:0] CAUSE_REDIR = 2'b11;

  localparam logic [CNT_W-1:0] MD_LAT_C = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic             load_hz;
  logic             md_hz;
  logic             md_issue;

  // The EX load targets a register that the ID instruction reads.
  // Register 0 is excluded because it is never really written.
  assign load_hz = EX_mem_read && (EX_reg_rt != 5'd0) &&
                   ((EX_reg_rt == ID_reg_rs) || (ID_uses_rt && (EX_reg_rt == ID_reg_rt)));
  assign md_busy  = (state == MD_BUSY);
  assign md_hz    = md_busy && (ID_is_md || ID_reads_hilo);
  // A wrong-path mult/div (redirect) or a stalled one must not start the unit.
  assign md_issue = ID_is_md && !EX_redirect && !md_hz && !load_hz;

  // State and busy-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state logic. The in-flight op keeps counting under a redirect.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_LAT_C;
        end
      end
      MD_BUSY: begin
        if (md_cnt == CNT_ONE) begin
          state_nxt  = IDLE;
          md_cnt_nxt = '0;
        end else begin
          md_cnt_nxt = md_cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline control outputs, prioritised: redirect > mult/div > load-use
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    stall_cause  = CAUSE_NONE;
    if (!reset) begin
      if (EX_redirect) begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        stall_cause  = CAUSE_REDIR;
      end else if (md_hz) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        stall_cause  = CAUSE_MD;
      end else if (load_hz) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        stall_cause  = CAUSE_LOAD;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stall-cycle statistics, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      load_stall_cnt <= '0;
      md_stall_cnt   <= '0;
    end else begin
      if (stall_cause == CAUSE_LOAD) load_stall_cnt <= sat_inc(load_stall_cnt);
      if (stall_cause == CAUSE_MD)   md_stall_cnt   <= sat_inc(md_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit (MD_LATENCY = 4).
// The control outputs are packed as {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, stall_cause}.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_reg_rs, ID_reg_rt, EX_reg_rt;
  logic       ID_uses_rt, ID_is_md, ID_reads_hilo, EX_mem_read, EX_redirect;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, md_busy;
  logic [1:0] stall_cause;
`ifdef HAZARD_STATS_EN
  logic [15:0] load_stall_cnt, md_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] NEUTRAL = 6'b110000;
  localparam logic [5:0] LOADST  = 6'b000101;
  localparam logic [5:0] MDST    = 6'b000110;
  localparam logic [5:0] REDIR   = 6'b111111;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_reg_rs(ID_reg_rs), .ID_reg_rt(ID_reg_rt), .ID_uses_rt(ID_uses_rt),
    .ID_is_md(ID_is_md), .ID_reads_hilo(ID_reads_hilo),
    .EX_mem_read(EX_mem_read), .EX_reg_rt(EX_reg_rt), .EX_redirect(EX_redirect),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .md_busy(md_busy),
`ifdef HAZARD_STATS_EN
    .load_stall_cnt(load_stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .stall_cause(stall_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, stall_cause}, {26'd0, exp});
  endtask

  // Advance one clock edge, then leave 1 time unit for outputs to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_reg_rs = 5'd0; ID_reg_rt = 5'd0; EX_reg_rt = 5'd0;
    ID_uses_rt = 1'b0; ID_is_md = 1'b0; ID_reads_hilo = 1'b0;
    EX_mem_read = 1'b0; EX_redirect = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    // While reset is high, a present load-use hazard must still give neutral outputs.
    EX_mem_read = 1'b1; EX_reg_rt = 5'd5; ID_reg_rs = 5'd5;
    #2;
    chk_ctl("reset_neutral", NEUTRAL);
    step();
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_cnt", {28'd0, dut.md_cnt}, 32'd0);
    clear_in();
    step();
    reset = 1'b0;
    #1;

    // Load-use stall on rs lasts one cycle.
    EX_mem_read = 1'b1; EX_reg_rt = 5'd5; ID_reg_rs = 5'd5;
    #1; chk_ctl("load_use_c1", LOADST);
    step();
    EX_mem_read = 1'b0;
    #1; chk_ctl("load_use_c2", NEUTRAL);
`ifdef HAZARD_STATS_EN
    chk("load_stat", {16'd0, load_stall_cnt}, 32'd1);
`endif

    // Register 0 never causes a hazard; rt matters only if it is used.
    clear_in();
    EX_mem_read = 1'b1; EX_reg_rt = 5'd0; ID_reg_rs = 5'd0;
    #1; chk_ctl("r0_no_hz", NEUTRAL);
    EX_reg_rt = 5'd7; ID_reg_rt = 5'd7; ID_reg_rs = 5'd3; ID_uses_rt = 1'b0;
    #1; chk_ctl("rt_unused", NEUTRAL);
    ID_uses_rt = 1'b1;
    #1; chk_ctl("rt_used", LOADST);
    clear_in();
    step();

    // Mult/div issue, then mfhi is held: busy for 4 cycles, mfhi proceeds in cycle 6.
    ID_is_md = 1'b1;
    #1; chk_ctl("md_issue", NEUTRAL);
    chk("md_issue_busy", {31'd0, md_busy}, 32'd0);
    step();
    ID_is_md = 1'b0; ID_reads_hilo = 1'b1;
    chk("md_cnt_load", {28'd0, dut.md_cnt}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("md_busy_%0d", i), {31'd0, md_busy}, 32'd1);
      chk_ctl($sformatf("md_stall_%0d", i), MDST);
      step();
    end
    #1;
    chk("mfhi_go_busy", {31'd0, md_busy}, 32'd0);
    chk_ctl("mfhi_go", NEUTRAL);
`ifdef HAZARD_STATS_EN
    chk("md_stat", {16'd0, md_stall_cnt}, 32'd4);
`endif
    clear_in();
    step();

    // Back-to-back mult/div: the second one stalls 4 cycles, then re-issues with no gap.
    ID_is_md = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("b2b_stall_%0d", i), MDST);
      step();
    end
    #1;
    chk_ctl("b2b_issue", NEUTRAL);
    chk("b2b_idle", {31'd0, md_busy}, 32'd0);
    step();
    chk("b2b_rebusy", {31'd0, md_busy}, 32'd1);
    chk("b2b_cnt", {28'd0, dut.md_cnt}, 32'd4);

    // A redirect overrides coincident md and load hazards; the counter keeps running.
    EX_redirect = 1'b1; ID_is_md = 1'b1;
    EX_mem_read = 1'b1; EX_reg_rt = 5'd5; ID_reg_rs = 5'd5;
    #1; chk_ctl("redirect_prio", REDIR);
    step();
    chk("redirect_cnt", {28'd0, dut.md_cnt}, 32'd3);
    clear_in();
    step();
    chk("pre_reset_cnt", {28'd0, dut.md_cnt}, 32'd2);

    // Reset in mid-operation clears the FSM and the counter.
    reset = 1'b1;
    step();
    chk("midrst_busy", {31'd0, md_busy}, 32'd0);
    chk("midrst_cnt", {28'd0, dut.md_cnt}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("midrst_lstat", {16'd0, load_stall_cnt}, 32'd0);
    chk("midrst_mstat", {16'd0, md_stall_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // A mult/div in ID under a redirect is not issued.
    EX_redirect = 1'b1; ID_is_md = 1'b1;
    #1; chk_ctl("redir_md_ctl", REDIR);
    step();
    chk("redir_md_noissue", {31'd0, md_busy}, 32'd0);
    clear_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
